mat_vec_stream_loader: RTL and testbench
========================================

Name: mat_vec_stream_loader

Overview:
- Initiator side of the product unit's input handshake.
- Accepts a serial stream of IEEE-754 single words, e.g. from the host UART/SPI deserializer.
- Assembles one 4x4 matrix plus one 4-vector, then presents all operands in parallel to matrix_vector_prod_seq with a valid/ready handshake.
- Supports vector-only frames that reuse the last loaded matrix, so repeated transforms cost 4 words instead of 20.

Parameters:
N, 4, matrix dimension and vector length
W, 32, operand word width (float32 bit pattern, never interpreted)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
s_word  in  W  stream data word
s_valid  in  1  stream word valid
s_last  in  1  marks final word of a frame
s_keep_matrix  in  1  sampled on first word of a frame; 1 = vector-only frame
s_ready  out  1  loader can accept a word
o_matrix  out  N*N*W  element (r,c) at bits [(r*N+c)*W +: W]
o_vector  out  N*W  element k at bits [k*W +: W]
o_valid  out  1  operands valid to product unit (drives its i_valid)
o_ready  in  1  product unit ready (its i_ready)
o_frame_err  out  1  one-cycle pulse on framing error

Behaviour:
- Reset (async, active-high): state IDLE; idx=0; mat_loaded=0; o_matrix=0; o_vector=0; o_valid=0; o_frame_err=0. s_ready=0 while rst is high.
- A word is accepted when s_valid && s_ready on a rising clk edge.
- s_ready=1 in IDLE, LOAD_MAT, LOAD_VEC and DRAIN; 0 in PRESENT.
- IDLE, first word accepted; s_keep_matrix is sampled on this word only:
  - keep=0: word goes to matrix element 0, idx=1, next state LOAD_MAT.
  - keep=1 and mat_loaded=1: word goes to vector element 0, idx=1, next state LOAD_VEC.
  - keep=1 and mat_loaded=0: error. Pulse o_frame_err, then DRAIN if s_last=0, else IDLE.
- LOAD_MAT:
  - Word k writes matrix element k (row-major); idx increments.
  - After element N*N-1: set mat_loaded=1, idx=0, next state LOAD_VEC.
- LOAD_VEC: word k writes vector element k.
  - After element N-1 with s_last=1: go to PRESENT.
  - After element N-1 with s_last=0: error; go to DRAIN.
- Early s_last (on any word before the final vector element): error; go to IDLE.
- Any error:
  - o_frame_err pulses high for exactly one cycle, the cycle after the offending acceptance.
  - mat_loaded is cleared if the matrix was partially or fully rewritten in that frame.
  - o_valid is never raised for the frame.
- DRAIN: accept and discard words until one with s_last=1 is accepted, then go to IDLE.
- PRESENT:
  - o_valid=1, and o_matrix/o_vector are held stable.
  - On o_valid && o_ready: o_valid=0 the next cycle, state IDLE.
- Latency: o_valid rises on the clock edge that accepts the final vector word, so it is visible the following cycle.
- Throughput: one word per cycle while loading. The next frame's first word may be accepted in the cycle after the handshake completes.
- o_matrix and o_vector change only on accepted words, so they hold contents between frames. The matrix survives vector-only frames.
- Reset mid-frame or mid-PRESENT: immediate return to reset values. A pending output is dropped with no handshake.
- Counter width: $clog2(N*N). idx never exceeds N*N-1 (matrix) or N-1 (vector).

Decomposition:
- Shared package mvp_pkg holds:
  - localparams N and W,
  - typedef logic [W-1:0] float_word_t,
  - loader state enum {IDLE, LOAD_MAT, LOAD_VEC, PRESENT, DRAIN}.
- The product unit and bench import the same package.
- No sub-module: one FSM, one index counter and the operand registers fit in a single module.

Test Plan:
- Full frame: identity matrix (3F800000 on the diagonal, 0 elsewhere), vector 3F800000,40000000,40400000,40800000 with s_last on word 20 -> o_valid rises the next cycle. Bus matches bit-exactly. Product unit returns 1.0,2.0,3.0,4.0 within FLOAT_ERROR.
- Vector-only frame after that: keep=1, vector 40A00000 x4 -> o_matrix unchanged, o_vector all 5.0, o_valid after word 4.
- Backpressure: hold o_ready=0 for 10 cycles in PRESENT -> s_ready=0, o_valid and data stable throughout. Handshake completes on o_ready=1, and the loader accepts the next first word one cycle later.
- Early s_last on word 7 -> o_frame_err single pulse, no o_valid. Next keep=1 frame errors because mat_loaded=0.
- Missing s_last on word 20 plus 3 extra words, last tagged -> one o_frame_err pulse. All extra words accepted and dropped, then the loader returns to IDLE.
- Reset asserted at word 12 -> s_ready=0 and all outputs 0 immediately. After release, a fresh 20-word frame completes normally.

Source files
------------

// File: rtl/mvp_pkg.sv
// Shared definitions for the matrix-vector product path: sizes, operand word type
// and the stream loader state encoding.
package mvp_pkg;
  localparam int N      = 4;
  localparam int W      = 32;
  localparam int IDX_W  = $clog2(N*N);
  localparam int VIDX_W = $clog2(N);

  typedef logic [W-1:0] float_word_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_MAT,
    LOAD_VEC,
    PRESENT,
    DRAIN
  } ld_state_t;
endpackage

// File: rtl/mat_vec_stream_loader.sv
// Collects a serial word stream into a 4x4 matrix plus 4-vector and presents
// them in parallel to the product unit; vector-only frames reuse the stored matrix.
module mat_vec_stream_loader
  import mvp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     s_word,
  input  logic             s_valid,
  input  logic             s_last,
  input  logic             s_keep_matrix,
  output logic             s_ready,
  output logic [N*N*W-1:0] o_matrix,
  output logic [N*W-1:0]   o_vector,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_frame_err
);

  ld_state_t        state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             mat_loaded, mat_loaded_n;
  logic             frame_mat, frame_mat_n;  // current frame is rewriting the matrix
  logic             err_n;
  logic             mat_we, vec_we;
  logic             acc;

  assign s_ready = !rst && (state != PRESENT);
  assign o_valid = (state == PRESENT);
  assign acc     = s_valid && s_ready;

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    mat_loaded_n = mat_loaded;
    frame_mat_n  = frame_mat;
    err_n        = 1'b0;
    mat_we       = 1'b0;
    vec_we       = 1'b0;
    case (state)
      IDLE: if (acc) begin
        idx_n = '0;
        if (!s_keep_matrix) begin
          mat_we       = 1'b1;
          frame_mat_n  = 1'b1;
          mat_loaded_n = 1'b0;  // restored only once all N*N elements land
          if (s_last) begin
            err_n = 1'b1;
          end else begin
            idx_n   = IDX_W'(1);
            state_n = LOAD_MAT;
          end
        end else if (mat_loaded) begin
          vec_we      = 1'b1;
          frame_mat_n = 1'b0;
          if (s_last) begin
            err_n = 1'b1;
          end else begin
            idx_n   = IDX_W'(1);
            state_n = LOAD_VEC;
          end
        end else begin
          err_n   = 1'b1;
          state_n = s_last ? IDLE : DRAIN;
        end
      end
      LOAD_MAT: if (acc) begin
        mat_we = 1'b1;
        if (s_last) begin
          err_n   = 1'b1;
          idx_n   = '0;
          state_n = IDLE;
        end else if (idx == IDX_W'(N*N-1)) begin
          mat_loaded_n = 1'b1;
          idx_n        = '0;
          state_n      = LOAD_VEC;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
      LOAD_VEC: if (acc) begin
        vec_we = 1'b1;
        if (idx == IDX_W'(N-1)) begin
          idx_n = '0;
          if (s_last) begin
            state_n = PRESENT;
          end else begin
            err_n   = 1'b1;
            state_n = DRAIN;
            if (frame_mat) mat_loaded_n = 1'b0;
          end
        end else if (s_last) begin
          err_n   = 1'b1;
          idx_n   = '0;
          state_n = IDLE;
          if (frame_mat) mat_loaded_n = 1'b0;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
      PRESENT: if (o_ready) state_n = IDLE;
      DRAIN:   if (acc && s_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      mat_loaded  <= 1'b0;
      frame_mat   <= 1'b0;
      o_frame_err <= 1'b0;
      o_matrix    <= '0;
      o_vector    <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      mat_loaded  <= mat_loaded_n;
      frame_mat   <= frame_mat_n;
      o_frame_err <= err_n;
      if (mat_we) o_matrix[int'(idx)*W +: W] <= s_word;
      if (vec_we) o_vector[int'(idx[VIDX_W-1:0])*W +: W] <= s_word;
    end
  end

endmodule

// File: tb/tb_mat_vec_stream_loader.sv
// Directed bench for the matrix/vector stream loader.
module tb_mat_vec_stream_loader;
  import mvp_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     s_word;
  logic             s_valid, s_last, s_keep_matrix, s_ready;
  logic [N*N*W-1:0] o_matrix;
  logic [N*W-1:0]   o_vector;
  logic             o_valid, o_ready, o_frame_err;

  int errors = 0;
  int checks = 0;

  logic [W-1:0]     st [24];
  logic [N*N*W-1:0] exp_mat;
  logic [N*W-1:0]   exp_vec;

  mat_vec_stream_loader dut (
    .clk(clk), .rst(rst), .s_word(s_word), .s_valid(s_valid), .s_last(s_last),
    .s_keep_matrix(s_keep_matrix), .s_ready(s_ready), .o_matrix(o_matrix),
    .o_vector(o_vector), .o_valid(o_valid), .o_ready(o_ready), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  // Called at a negedge: presents one word, lets it be taken, returns at the next negedge.
  task automatic send_word(input logic [W-1:0] w, input logic last, input logic keep);
    s_word = w; s_valid = 1'b1; s_last = last; s_keep_matrix = keep;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic send_stream(input int first, input int n, input int last_pos, input logic keep);
    for (int i = first; i < first + n; i++)
      send_word(st[i], i == last_pos, (i == 0) ? keep : 1'b0);
  endtask

  task automatic build_exp_full();
    for (int k = 0; k < N*N; k++) exp_mat[k*W +: W] = st[k];
    for (int k = 0; k < N; k++)   exp_vec[k*W +: W] = st[N*N + k];
  endtask

  task automatic handshake();
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL handshake_drop o_valid=%b want 0", o_valid); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL handshake_sready s_ready=%b want 1", s_ready); end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_keep_matrix = 1'b0; s_word = '0; o_ready = 1'b0;
    tick(); tick();
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_sready s_ready=%b want 0", s_ready); end
    checks++; if (o_valid !== 1'b0 || o_frame_err !== 1'b0) begin errors++; $display("FAIL rst_flags valid=%b err=%b want 0 0", o_valid, o_frame_err); end
    checks++; if (o_matrix !== '0 || o_vector !== '0) begin errors++; $display("FAIL rst_data mat=%h vec=%h want 0", o_matrix, o_vector); end
    rst = 1'b0;
    tick();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_release s_ready=%b want 1", s_ready); end
  endtask

  task automatic test_full_frame();
    for (int k = 0; k < N*N; k++) st[k] = ((k / N) == (k % N)) ? 32'h3F80_0000 : 32'h0;
    st[16] = 32'h3F80_0000; st[17] = 32'h4000_0000; st[18] = 32'h4040_0000; st[19] = 32'h4080_0000;
    build_exp_full();
    send_stream(0, 19, 19, 1'b0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid o_valid=%b want 0", o_valid); end
    send_stream(19, 1, 19, 1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (o_valid !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL full_present valid=%b s_ready=%b want 1 0", o_valid, s_ready); end
    checks++; if (o_matrix !== exp_mat) begin errors++; $display("FAIL full_matrix got=%h want=%h", o_matrix, exp_mat); end
    checks++; if (o_vector !== exp_vec) begin errors++; $display("FAIL full_vector got=%h want=%h", o_vector, exp_vec); end
    checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL full_err o_frame_err=%b want 0", o_frame_err); end
    handshake();
  endtask

  task automatic test_vec_only();
    for (int k = 0; k < N; k++) st[k] = 32'h40A0_0000;
    for (int k = 0; k < N; k++) exp_vec[k*W +: W] = 32'h40A0_0000;
    send_stream(0, 3, 3, 1'b1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL vec_early_valid o_valid=%b want 0", o_valid); end
    send_stream(3, 1, 3, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL vec_present o_valid=%b want 1", o_valid); end
    checks++; if (o_matrix !== exp_mat) begin errors++; $display("FAIL vec_matrix_kept got=%h want=%h", o_matrix, exp_mat); end
    checks++; if (o_vector !== exp_vec) begin errors++; $display("FAIL vec_vector got=%h want=%h", o_vector, exp_vec); end
  endtask

  // Still in PRESENT from the vector-only frame; the next frame's first word waits on s_valid.
  task automatic test_back_to_back();
    int bad;
    for (int k = 0; k < 20; k++) st[k] = 32'h4100_0000 + k;
    bad = 0;
    s_word = st[0]; s_valid = 1'b1; s_last = 1'b0; s_keep_matrix = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (s_ready !== 1'b0 || o_valid !== 1'b1 || o_vector !== exp_vec || o_matrix !== exp_mat) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_stable bad_cycles=%0d want 0", bad); end
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    checks++; if (o_valid !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL stall_release valid=%b s_ready=%b want 0 1", o_valid, s_ready); end
    tick();
    send_stream(1, 19, 19, 1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    build_exp_full();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL b2b_present o_valid=%b want 1", o_valid); end
    checks++; if (o_matrix !== exp_mat || o_vector !== exp_vec) begin errors++; $display("FAIL b2b_data mat=%h vec=%h want %h %h", o_matrix, o_vector, exp_mat, exp_vec); end
    handshake();
  endtask

  task automatic test_early_last();
    int vld_seen;
    for (int k = 0; k < 20; k++) st[k] = 32'hC000_0000 | (k << 4);
    for (int k = 0; k < 7; k++) exp_mat[k*W +: W] = st[k];
    send_stream(0, 7, 6, 1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (o_frame_err !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL early_err err=%b valid=%b want 1 0", o_frame_err, o_valid); end
    tick();
    checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL early_pulse o_frame_err=%b want 0", o_frame_err); end
    checks++; if (o_matrix !== exp_mat) begin errors++; $display("FAIL early_partial got=%h want=%h", o_matrix, exp_mat); end
    send_word(32'h1111_1111, 1'b0, 1'b1);
    checks++; if (o_frame_err !== 1'b1) begin errors++; $display("FAIL keep_unloaded_err o_frame_err=%b want 1", o_frame_err); end
    vld_seen = 0;
    send_word(32'h2222_2222, 1'b0, 1'b0);
    checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL keep_unloaded_pulse o_frame_err=%b want 0", o_frame_err); end
    send_word(32'h3333_3333, 1'b0, 1'b0);
    send_word(32'h4444_4444, 1'b1, 1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    if (o_valid) vld_seen++;
    tick();
    if (o_valid) vld_seen++;
    checks++; if (vld_seen != 0 || s_ready !== 1'b1) begin errors++; $display("FAIL drain_idle valid_cycles=%0d s_ready=%b want 0 1", vld_seen, s_ready); end
    checks++; if (o_vector !== exp_vec) begin errors++; $display("FAIL drain_dropped vec=%h want=%h", o_vector, exp_vec); end
  endtask

  task automatic test_missing_last();
    for (int k = 0; k < 20; k++) st[k] = 32'h5000_0000 + (k * 3);
    st[20] = 32'hAAAA_0000; st[21] = 32'hBBBB_0000; st[22] = 32'hCCCC_0000;
    build_exp_full();
    send_stream(0, 20, 99, 1'b0);
    checks++; if (o_frame_err !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL miss_err err=%b valid=%b want 1 0", o_frame_err, o_valid); end
    send_stream(20, 1, 22, 1'b0);
    checks++; if (o_frame_err !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL miss_pulse err=%b s_ready=%b want 0 1", o_frame_err, s_ready); end
    send_stream(21, 2, 22, 1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    checks++; if (o_valid !== 1'b0 || o_frame_err !== 1'b0) begin errors++; $display("FAIL miss_idle valid=%b err=%b want 0 0", o_valid, o_frame_err); end
    checks++; if (o_matrix !== exp_mat || o_vector !== exp_vec) begin errors++; $display("FAIL miss_data mat=%h vec=%h want %h %h", o_matrix, o_vector, exp_mat, exp_vec); end
    send_word(32'h40A0_0000, 1'b1, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (o_frame_err !== 1'b1) begin errors++; $display("FAIL miss_mat_cleared o_frame_err=%b want 1", o_frame_err); end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    for (int k = 0; k < 20; k++) st[k] = 32'h6000_0000 + k;
    send_stream(0, 11, 99, 1'b0);
    s_word = st[11]; s_valid = 1'b1; s_last = 1'b0; s_keep_matrix = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0 || o_valid !== 1'b0 || o_frame_err !== 1'b0) begin errors++; $display("FAIL midrst_flags s_ready=%b valid=%b err=%b want 0 0 0", s_ready, o_valid, o_frame_err); end
    checks++; if (o_matrix !== '0 || o_vector !== '0) begin errors++; $display("FAIL midrst_data mat=%h vec=%h want 0", o_matrix, o_vector); end
    tick();
    rst = 1'b0; s_valid = 1'b0;
    tick();
    for (int k = 0; k < N*N; k++) st[k] = ((k / N) == (k % N)) ? 32'h3F80_0000 : 32'h0;
    st[16] = 32'h3F80_0000; st[17] = 32'h4000_0000; st[18] = 32'h4040_0000; st[19] = 32'h4080_0000;
    build_exp_full();
    send_stream(0, 20, 19, 1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL postrst_valid o_valid=%b want 1", o_valid); end
    checks++; if (o_matrix !== exp_mat || o_vector !== exp_vec) begin errors++; $display("FAIL postrst_data mat=%h vec=%h want %h %h", o_matrix, o_vector, exp_mat, exp_vec); end
    handshake();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_vec_only();
    test_back_to_back();
    test_early_last();
    test_missing_last();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
